// File: rtl/adder_share_arb_pkg.sv
// Shared helpers for the adder-sharing scheduler: id/pointer width derivation.
package adder_share_arb_pkg;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant on the first request at or after ptr,
// wrapping modulo N; ptr moves past the winner only on a grant.
module rr_arbiter
    import adder_share_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = id_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW:0]   cand;
    logic          found;

    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (en && !found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
        if (found) gnt[idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/ripple_carry_adder.sv
// W-bit ripple-carry adder; purely combinational, carry chain runs LSB to MSB.
module ripple_carry_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/adder_share_arb.sv
// Shares one ripple-carry adder between N requesters via a round-robin grant
// and a single registered result slot with valid/ready backpressure.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int  W   = 4,
    parameter int  N   = 4,
    localparam int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_flat,
    input  logic [N*W-1:0] b_flat,
    input  logic [N-1:0]   ci,
    output logic [N-1:0]   gnt,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_sum,
    output logic           res_co,
    output logic [IDW-1:0] res_id
);

    logic           free;
    logic           en;
    logic           grant;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           ci_sel;
    logic [IDW-1:0] id_sel;
    logic [W-1:0]   sum;
    logic           co;

    assign free  = !res_valid || res_ready;
    assign en    = free && !rst;
    assign grant = |gnt;

    rr_arbiter #(.N(N)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (en),
        .gnt (gnt)
    );

    // One-hot mux: at most one gnt bit is set, so the last match is the only match.
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        ci_sel = 1'b0;
        id_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                a_sel  = a_flat[k*W +: W];
                b_sel  = b_flat[k*W +: W];
                ci_sel = ci[k];
                id_sel = IDW'(k);
            end
        end
    end

    ripple_carry_adder #(.W(W)) u_add (
        .a  (a_sel),
        .b  (b_sel),
        .ci (ci_sel),
        .s  (sum),
        .co (co)
    );

    // A grant always wins over a plain consume, giving back-to-back results.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_co    <= 1'b0;
            res_id    <= '0;
        end else if (grant) begin
            res_valid <= 1'b1;
            res_sum   <= sum;
            res_co    <= co;
            res_id    <= id_sel;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
